// File: rtl/pmp_seq_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cep_define                                                               |
// | Shared PMP types, CSR map and cfg legalisation (PMP_NAPOT_EN aware).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cep_define;

  localparam logic [31:0] CSR_PMPCFG0  = 32'h0000_03A0;
  localparam logic [31:0] CSR_PMPADDR0 = 32'h0000_03B0;
  localparam logic [1:0]  PRIV_M       = 2'b11;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_amode_e;

  typedef enum logic [1:0] {
    OPER_READ  = 2'd0,
    OPER_WRITE = 2'd1,
    OPER_EXEC  = 2'd2
  } pmp_oper_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_amode_e a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  // Reserved bits always read back as zero; naturally-aligned modes fold to OFF
  // when the NAPOT/NA4 matcher is not built.
  function automatic pmp_cfg_t cfg_legalize(input logic [7:0] raw);
    pmp_cfg_t c;
    c      = pmp_cfg_t'(raw);
    c.rsvd = 2'b00;
`ifdef PMP_NAPOT_EN
    c.a    = c.a;
`else
    if (c.a == A_NA4 || c.a == A_NAPOT) begin
      c.a = A_OFF;
    end
`endif
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmp_entry_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmp_entry_match                                                          |
// | Combinational range and permission check of one PMP entry.               |
// | NA4/NAPOT decoding only when PMP_NAPOT_EN is defined.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pmp_entry_match
  import cep_define::*;
(
  input  pmp_cfg_t    cfg,
  input  logic [31:0] addr_prev,
  input  logic [31:0] addr_cur,
  input  logic [31:0] acc_addr,
  input  logic [1:0]  acc_size,
  input  logic [1:0]  priv_mode,
  input  pmp_oper_e   oper,
  output logic        hit,
  output logic        allow
);

  // 36-bit byte addresses so that region ends up to 2^35 never wrap.
  logic [35:0] acc_lo;
  logic [35:0] acc_hi;
  logic [35:0] rgn_lo;
  logic [35:0] rgn_hi;
  logic        rgn_en;
  logic        contained;
  logic        perm;

  assign acc_lo = {4'b0000, acc_addr};
  assign acc_hi = acc_lo + (36'd1 << acc_size);

`ifdef PMP_NAPOT_EN
  logic [35:0] napot_p;
  logic [35:0] napot_len;
  assign napot_p   = {4'b0000, addr_cur};
  assign napot_len = ((napot_p ^ (napot_p + 36'd1)) + 36'd1) << 2;
`endif

  always_comb begin
    rgn_lo = '0;
    rgn_hi = '0;
    rgn_en = 1'b0;
    case (cfg.a)
      A_TOR: begin
        rgn_lo = {2'b00, addr_prev, 2'b00};
        rgn_hi = {2'b00, addr_cur, 2'b00};
        rgn_en = 1'b1;
      end
`ifdef PMP_NAPOT_EN
      A_NA4: begin
        rgn_lo = {2'b00, addr_cur, 2'b00};
        rgn_hi = {2'b00, addr_cur, 2'b00} + 36'd4;
        rgn_en = 1'b1;
      end
      A_NAPOT: begin
        rgn_lo = (napot_p & (napot_p + 36'd1)) << 2;
        rgn_hi = ((napot_p & (napot_p + 36'd1)) << 2) + napot_len;
        rgn_en = 1'b1;
      end
`endif
      default: begin
        rgn_en = 1'b0;
      end
    endcase
  end

  // An empty TOR region (lo >= hi) must not register even a partial overlap.
  assign hit       = rgn_en && (rgn_lo < rgn_hi) && (acc_lo < rgn_hi) && (acc_hi > rgn_lo);
  assign contained = rgn_en && (rgn_lo < rgn_hi) && (acc_lo >= rgn_lo) && (acc_hi <= rgn_hi);

  always_comb begin
    perm = 1'b0;
    case (oper)
      OPER_READ:  perm = cfg.r;
      OPER_WRITE: perm = cfg.w;
      OPER_EXEC:  perm = cfg.x;
      default:    perm = 1'b0;
    endcase
  end

  assign allow = contained && (((priv_mode == PRIV_M) && !cfg.l) || perm);

endmodule
`default_nettype wire

// File: rtl/pmp_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmp_seq_checker                                                          |
// | Sequential PMP checker: CSR file plus a multi-cycle grouped entry scan.  |
// | Define PMP_NAPOT_EN to enable NA4/NAPOT region matching.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pmp_seq_checker
  import cep_define::*;
#(
  parameter int NUM_ENTRIES       = 16,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [31:0]                    rw_addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     priv_mode,
  input  logic [1:0]                     oper,
  input  logic [31:0]                    addr,
  input  logic [1:0]                     size,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_allow,
  output logic                           resp_hit,
  output logic [$clog2(NUM_ENTRIES)-1:0] resp_idx
);

  localparam int IDX_W         = $clog2(NUM_ENTRIES);
  localparam int NUM_GRPS      = NUM_ENTRIES / ENTRIES_PER_CYCLE;
  localparam int GRP_W         = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;
  localparam int NUM_CFG_WORDS = NUM_ENTRIES / 4;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  pmp_cfg_t [NUM_ENTRIES-1:0]        cfg_q, cfg_d;
  logic     [NUM_ENTRIES-1:0][31:0]  paddr_q, paddr_d;
  logic     [NUM_ENTRIES-1:0]        addr_locked;
  logic     [31:0]                   rdata_q, rdata_d, rd_mux;

  logic [1:0]       state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             allow_q, allow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       rq_priv_q, rq_priv_d;
  logic [1:0]       rq_oper_q, rq_oper_d;
  logic [1:0]       rq_size_q, rq_size_d;
  logic [31:0]      rq_addr_q, rq_addr_d;

  pmp_cfg_t [ENTRIES_PER_CYCLE-1:0]            lane_cfg;
  logic     [ENTRIES_PER_CYCLE-1:0][IDX_W-1:0] lane_idx;
  logic     [ENTRIES_PER_CYCLE-1:0][31:0]      lane_cur;
  logic     [ENTRIES_PER_CYCLE-1:0][31:0]      lane_prev;
  logic     [ENTRIES_PER_CYCLE-1:0]            lane_hit;
  logic     [ENTRIES_PER_CYCLE-1:0]            lane_allow;
  logic                                        scan_hit;
  logic                                        scan_allow;
  logic     [IDX_W-1:0]                        scan_idx;

  // A locked TOR entry also freezes the address register that forms its base.
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_lock
    if (i < NUM_ENTRIES - 1) begin : g_mid
      assign addr_locked[i] = cfg_q[i].l | ((cfg_q[i+1].a == A_TOR) & cfg_q[i+1].l);
    end else begin : g_last
      assign addr_locked[i] = cfg_q[i].l;
    end
  end

  always_comb begin
    cfg_d   = cfg_q;
    paddr_d = paddr_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((rw_addr == CSR_PMPCFG0 + 32'(i / 4)) && !cfg_q[i].l) begin
          cfg_d[i] = cfg_legalize(wdata[8*(i%4) +: 8]);
        end
        if ((rw_addr == CSR_PMPADDR0 + 32'(i)) && !addr_locked[i]) begin
          paddr_d[i] = wdata;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CFG_WORDS; k++) begin
      if (rw_addr == CSR_PMPCFG0 + 32'(k)) begin
        rd_mux = {cfg_q[4*k+3], cfg_q[4*k+2], cfg_q[4*k+1], cfg_q[4*k]};
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rw_addr == CSR_PMPADDR0 + 32'(i)) begin
        rd_mux = paddr_q[i];
      end
    end
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  for (genvar j = 0; j < ENTRIES_PER_CYCLE; j++) begin : g_lane
    assign lane_idx[j]  = IDX_W'(int'(grp_q) * ENTRIES_PER_CYCLE + j);
    assign lane_cfg[j]  = cfg_q[lane_idx[j]];
    assign lane_cur[j]  = paddr_q[lane_idx[j]];
    assign lane_prev[j] = (lane_idx[j] == '0) ? 32'd0 : paddr_q[lane_idx[j] - 1'b1];

    pmp_entry_match u_match (
      .cfg       (lane_cfg[j]),
      .addr_prev (lane_prev[j]),
      .addr_cur  (lane_cur[j]),
      .acc_addr  (rq_addr_q),
      .acc_size  (rq_size_q),
      .priv_mode (rq_priv_q),
      .oper      (pmp_oper_e'(rq_oper_q)),
      .hit       (lane_hit[j]),
      .allow     (lane_allow[j])
    );
  end

  always_comb begin
    scan_hit   = 1'b0;
    scan_allow = 1'b0;
    scan_idx   = '0;
    for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
      if (lane_hit[j]) begin
        scan_hit   = 1'b1;
        scan_allow = lane_allow[j];
        scan_idx   = lane_idx[j];
      end
    end
  end

  // Each group's verdict is registered; the state moves to RESP one cycle
  // after the deciding group, giving g+2 cycles from accept to resp_valid.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    done_d    = done_q;
    hit_d     = hit_q;
    allow_d   = allow_q;
    idx_d     = idx_q;
    rq_priv_d = rq_priv_q;
    rq_oper_d = rq_oper_q;
    rq_size_d = rq_size_q;
    rq_addr_d = rq_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rq_priv_d = priv_mode;
          rq_oper_d = oper;
          rq_size_d = size;
          rq_addr_d = addr;
          grp_d     = '0;
          done_d    = 1'b0;
          hit_d     = 1'b0;
          allow_d   = 1'b0;
          idx_d     = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (done_q) begin
          state_d = ST_RESP;
        end else begin
          hit_d   = scan_hit;
          allow_d = scan_hit ? scan_allow : (rq_priv_q == PRIV_M);
          idx_d   = scan_hit ? scan_idx : '0;
          done_d  = scan_hit || (grp_q == LAST_GRP);
          grp_d   = grp_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_q     <= '0;
      paddr_q   <= '0;
      rdata_q   <= '0;
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      allow_q   <= 1'b0;
      idx_q     <= '0;
      rq_priv_q <= '0;
      rq_oper_q <= '0;
      rq_size_q <= '0;
      rq_addr_q <= '0;
    end else begin
      cfg_q     <= cfg_d;
      paddr_q   <= paddr_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      grp_q     <= grp_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      allow_q   <= allow_d;
      idx_q     <= idx_d;
      rq_priv_q <= rq_priv_d;
      rq_oper_q <= rq_oper_d;
      rq_size_q <= rq_size_d;
      rq_addr_q <= rq_addr_d;
    end
  end

  assign rdata      = rdata_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_allow = allow_q;
  assign resp_hit   = hit_q;
  assign resp_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pmp_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pmp_seq_checker                                                       |
// | Directed and random checks of pmp_seq_checker against a range model.     |
// | Follows PMP_NAPOT_EN the same way as the design.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pmp_seq_checker;

  localparam int N  = 16;
  localparam int E  = 4;
  localparam int IW = $clog2(N);
  localparam logic [31:0] CFG0  = 32'h0000_03A0;
  localparam logic [31:0] ADDR0 = 32'h0000_03B0;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic          wr_en      = 1'b0;
  logic          rd_en      = 1'b0;
  logic [31:0]   rw_addr    = '0;
  logic [31:0]   wdata      = '0;
  logic [31:0]   rdata;
  logic          req_valid  = 1'b0;
  logic          req_ready;
  logic [1:0]    priv_mode  = '0;
  logic [1:0]    oper       = '0;
  logic [31:0]   addr       = '0;
  logic [1:0]    size       = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_allow;
  logic          resp_hit;
  logic [IW-1:0] resp_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_cfg  [N];
  logic [31:0] m_addr [N];

  pmp_seq_checker #(.NUM_ENTRIES(N), .ENTRIES_PER_CYCLE(E)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .rw_addr(rw_addr), .wdata(wdata), .rdata(rdata),
    .req_valid(req_valid), .req_ready(req_ready), .priv_mode(priv_mode),
    .oper(oper), .addr(addr), .size(size), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_allow(resp_allow), .resp_hit(resp_hit),
    .resp_idx(resp_idx)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear;
    for (int i = 0; i < N; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = 32'h0;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    model_clear;
  endtask

  function automatic logic [7:0] m_legal(input logic [7:0] v);
    logic [7:0] r;
    r = v & 8'h9F;
`ifndef PMP_NAPOT_EN
    if (r[4]) r[4:3] = 2'b00;
`endif
    return r;
  endfunction

  task automatic csr_write(input logic [31:0] a, input logic [31:0] d);
    int  k;
    bit  lockd;
    wr_en = 1'b1; rw_addr = a; wdata = d;
    tick;
    wr_en = 1'b0;
    if (a >= CFG0 && a < CFG0 + N / 4) begin
      k = int'(a - CFG0);
      for (int b = 0; b < 4; b++)
        if (!m_cfg[4*k+b][7]) m_cfg[4*k+b] = m_legal(d[8*b +: 8]);
    end else if (a >= ADDR0 && a < ADDR0 + N) begin
      k = int'(a - ADDR0);
      lockd = m_cfg[k][7];
      if (k < N - 1)
        if (m_cfg[k+1][4:3] == 2'd1 && m_cfg[k+1][7]) lockd = 1'b1;
      if (!lockd) m_addr[k] = d;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int k;
    if (a >= CFG0 && a < CFG0 + N / 4) begin
      k = int'(a - CFG0);
      return {m_cfg[4*k+3], m_cfg[4*k+2], m_cfg[4*k+1], m_cfg[4*k]};
    end
    if (a >= ADDR0 && a < ADDR0 + N) return m_addr[int'(a - ADDR0)];
    return 32'h0;
  endfunction

  task automatic csr_read_chk(input logic [31:0] a, input string tag);
    rd_en = 1'b1; rw_addr = a;
    tick;
    rd_en = 1'b0;
    chk(tag, rdata, m_read(a));
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < N / 4; k++) csr_read_chk(CFG0 + 32'(k), {tag, "_cfg"});
    for (int i = 0; i < N; i++) csr_read_chk(ADDR0 + 32'(i), {tag, "_addr"});
  endtask

  // First entry (lowest index) whose region touches the access decides.
  function automatic void model_check(input logic [1:0] pv, input logic [1:0] op,
                                      input logic [31:0] a, input logic [1:0] sz,
                                      output bit h, output bit al, output int ix);
    longint alo, ahi, lo, hi, len;
    int t;
    bit en;
    logic [7:0] c;
    h = 1'b0; al = (pv == 2'b11); ix = 0;
    alo = longint'(a);
    ahi = alo + (longint'(1) << sz);
    for (int i = 0; i < N; i++) begin
      c = m_cfg[i]; en = 1'b1; lo = 0; hi = 0;
      case (c[4:3])
        2'd1: begin
          lo = (i == 0) ? 0 : longint'(m_addr[i-1]) * 4;
          hi = longint'(m_addr[i]) * 4;
        end
        2'd2: begin
          lo = longint'(m_addr[i]) * 4;
          hi = lo + 4;
        end
        2'd3: begin
          t = 0;
          while (t < 32 && m_addr[i][t]) t++;
          len = longint'(1) << (t + 3);
          lo = (longint'(m_addr[i]) * 4) / len * len;
          hi = lo + len;
        end
        default: en = 1'b0;
      endcase
      if (en && lo < hi && alo < hi && ahi > lo) begin
        h = 1'b1; ix = i;
        if (alo >= lo && ahi <= hi) begin
          if (pv == 2'b11 && !c[7]) al = 1'b1;
          else al = (op == 2'd0) ? c[0] : (op == 2'd1) ? c[1] : (op == 2'd2) ? c[2] : 1'b0;
        end else begin
          al = 1'b0;
        end
        return;
      end
    end
  endfunction

  task automatic do_req(input logic [1:0] pv, input logic [1:0] op, input logic [31:0] a,
                        input logic [1:0] sz, input int hold, input string tag);
    bit eh, ea;
    int ei, lat, guard;
    model_check(pv, op, a, sz, eh, ea, ei);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin tick; guard++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; priv_mode = pv; oper = op; addr = a; size = sz;
    tick;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin tick; lat++; end
    chk({tag, "_lat"}, lat, eh ? (ei / E + 2) : (N / E + 1));
    chk({tag, "_hit"}, resp_hit, eh);
    chk({tag, "_allow"}, resp_allow, ea);
    chk({tag, "_idx"}, resp_idx, ei);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk({tag, "_hold"}, {req_ready, resp_valid, resp_hit, resp_allow, resp_idx},
          {1'b0, 1'b1, eh, ea, IW'(ei)});
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({tag, "_done"}, {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    bit seen;
    logic [31:0] d;
    model_clear;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_outputs", {req_ready, resp_valid, resp_hit, resp_allow, resp_idx, rdata},
        {1'b1, 1'b0, 1'b0, 1'b0, IW'(0), 32'h0});
    csr_read_chk(CFG0, "rst_cfg0");
    do_req(2'b01, 2'd0, 32'h1000, 2'd2, 0, "nohit_user");

    // TOR entry 0 over [0, 0x1000): contained vs straddling access
    csr_write(ADDR0, 32'h400);
    csr_write(CFG0, 32'h0000_0009);
    csr_read_chk(CFG0, "cfg0_tor");
    do_req(2'b01, 2'd0, 32'h0FFC, 2'd2, 0, "tor_full");
    do_req(2'b01, 2'd0, 32'h0FFE, 2'd2, 0, "tor_partial");

    // Locked TOR entry 5 freezes pmpaddr4 and pmpaddr5
    csr_write(ADDR0 + 4, 32'h800);
    csr_write(ADDR0 + 5, 32'h900);
    csr_write(CFG0 + 1, 32'h0000_8C00);
    csr_write(ADDR0 + 4, 32'h0);
    csr_write(ADDR0 + 5, 32'h0);
    chk("lock_addr4_model", m_addr[4], 32'h800);
    csr_read_chk(ADDR0 + 4, "lock_addr4");
    csr_read_chk(ADDR0 + 5, "lock_addr5");
    csr_write(CFG0 + 1, 32'h0300_0001);
    csr_read_chk(CFG0 + 1, "lock_cfg1_partial");
    do_req(2'b11, 2'd1, 32'h2100, 2'd2, 0, "locked_mmode");

    // Last entry only: worst-case latency plus back-pressure
    csr_write(ADDR0 + 14, 32'h2000);
    csr_write(ADDR0 + 15, 32'h2100);
    csr_write(CFG0 + 3, 32'h0900_0000);
    do_req(2'b01, 2'd0, 32'h8000, 2'd2, 3, "last_entry");

    // Unmapped addresses
    csr_write(CFG0 + N / 4, 32'hFFFF_FFFF);
    csr_read_chk(CFG0 + N / 4, "unmapped_cfg");
    csr_read_chk(ADDR0 + N, "unmapped_addr");

    // NAPOT region [0, 0x1000) on entry 2 (folds to OFF without the feature)
    do_reset;
    csr_write(ADDR0 + 2, 32'h1FF);
    csr_write(CFG0, 32'h0019_0000);
    csr_read_chk(CFG0, "napot_cfg0");
    do_req(2'b01, 2'd0, 32'h0FF8, 2'd3, 0, "napot_req");
    do_req(2'b01, 2'd0, 32'h0FFC, 2'd3, 0, "napot_edge");

    // Reset in the middle of a scan
    do_reset;
    csr_write(ADDR0, 32'h10);
    csr_write(CFG0, 32'h0000_0089);
    csr_write(ADDR0 + 15, 32'h3000);
    csr_write(CFG0 + 3, 32'h8900_0000);
    req_valid = 1'b1; priv_mode = 2'b01; oper = 2'd0; addr = 32'h5000; size = 2'd2;
    tick;
    req_valid = 1'b0;
    tick;
    chk("scan_busy", req_ready, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_clear;
    chk("abort_outputs", {req_ready, resp_valid, resp_hit, resp_allow, resp_idx, rdata},
        {1'b1, 1'b0, 1'b0, 1'b0, IW'(0), 32'h0});
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_resp", seen, 1'b0);
    read_all("abort");
    csr_write(ADDR0, 32'h55);
    csr_read_chk(ADDR0, "unlocked_addr0");

    // Random programming and requests
    for (int r = 0; r < 4; r++) begin
      do_reset;
      for (int w = 0; w < 14; w++) begin
        if ($urandom % 2 == 0) begin
          csr_write(ADDR0 + 32'($urandom % N), $urandom % 32'h400);
        end else begin
          d = $urandom;
          for (int b = 0; b < 4; b++) d[8*b+7] = ($urandom % 6 == 0);
          csr_write(CFG0 + 32'($urandom % (N / 4)), d);
        end
      end
      for (int q = 0; q < 10; q++) begin
        do_req(2'($urandom % 4), 2'($urandom % 3), $urandom % 32'h1100,
               2'($urandom % 4), int'($urandom % 3), "rnd_req");
      end
      read_all("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
